// File: rtl/multi_edge_detect_if.sv
// Signal bundle for multi_edge_detect: control/raw inputs in, per-channel edge/event state out.
// The master modport drives the inputs and the slave modport (the detector) drives the outputs.
interface multi_edge_detect_if #(
  parameter int unsigned Channels = 8,
  parameter int unsigned CntW     = 8
);
  logic                       en_i;
  logic [Channels-1:0]        a_i;
  logic [2*Channels-1:0]      mode_i;
  logic [Channels-1:0]        clr_sticky_i;
  logic [Channels-1:0]        clr_cnt_i;
  logic [Channels-1:0]        rising_edge_o;
  logic [Channels-1:0]        falling_edge_o;
  logic [Channels-1:0]        event_o;
  logic [Channels-1:0]        sticky_o;
  logic                       any_event_o;
  logic [Channels*CntW-1:0]   count_o;

  modport master (
    output en_i, a_i, mode_i, clr_sticky_i, clr_cnt_i,
    input  rising_edge_o, falling_edge_o, event_o, sticky_o, any_event_o, count_o
  );

  modport slave (
    input  en_i, a_i, mode_i, clr_sticky_i, clr_cnt_i,
    output rising_edge_o, falling_edge_o, event_o, sticky_o, any_event_o, count_o
  );
endinterface

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter, rise/fall pulses,
// mode-masked event, sticky flag and saturating event counter.
module multi_edge_detect #(
  parameter int unsigned Channels   = 8,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned FilterLen  = 3,
  parameter int unsigned CntW       = 8
) (
  input logic              clk,
  input logic              reset,
  multi_edge_detect_if.slave bus
);

  localparam int unsigned FcntW = (FilterLen > 1) ? $clog2(FilterLen) : 1;

  logic [Channels-1:0] sync_q [SyncStages];
  logic [Channels-1:0] s;
  logic [Channels-1:0] filt_q, filt_d;
  logic [FcntW-1:0]    fcnt_q [Channels];
  logic [FcntW-1:0]    fcnt_d [Channels];
  logic [Channels-1:0] rise_q, rise_d;
  logic [Channels-1:0] fall_q, fall_d;
  logic [Channels-1:0] event_q, event_d;
  logic [Channels-1:0] sticky_q, sticky_d;
  logic [CntW-1:0]     count_q [Channels];
  logic [CntW-1:0]     count_d [Channels];

  assign s = sync_q[SyncStages-1];

  // Filter runs regardless of en so a re-enable never reports a stale change.
  always_comb begin
    for (int i = 0; i < Channels; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (s[i] != filt_q[i]) begin
        if (fcnt_q[i] == FcntW'(FilterLen - 1)) begin
          filt_d[i] = s[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + FcntW'(1);
        end
      end
    end
  end

  always_comb begin
    rise_d = {Channels{bus.en_i}} & filt_d & ~filt_q;
    fall_d = {Channels{bus.en_i}} & ~filt_d & filt_q;
    event_d = '0;
    for (int i = 0; i < Channels; i++) begin
      event_d[i] = (rise_d[i] & bus.mode_i[2*i]) | (fall_d[i] & bus.mode_i[2*i+1]);
    end
  end

  // Sticky and count follow the registered event, so a clear seen alongside it loses.
  always_comb begin
    sticky_d = event_q | (sticky_q & ~bus.clr_sticky_i);
    for (int i = 0; i < Channels; i++) begin
      count_d[i] = count_q[i];
      if (bus.clr_cnt_i[i]) begin
        count_d[i] = event_q[i] ? CntW'(1) : '0;
      end else if (event_q[i] && (count_q[i] != {CntW{1'b1}})) begin
        count_d[i] = count_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SyncStages; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < Channels; i++) begin
        fcnt_q[i]  <= '0;
        count_q[i] <= '0;
      end
      filt_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      event_q  <= '0;
      sticky_q <= '0;
    end else begin
      sync_q[0] <= bus.a_i;
      for (int k = 1; k < SyncStages; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int i = 0; i < Channels; i++) begin
        fcnt_q[i]  <= fcnt_d[i];
        count_q[i] <= count_d[i];
      end
      filt_q   <= filt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      event_q  <= event_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    bus.count_o = '0;
    for (int i = 0; i < Channels; i++) begin
      bus.count_o[i*CntW +: CntW] = count_q[i];
    end
  end

  assign bus.rising_edge_o  = rise_q;
  assign bus.falling_edge_o = fall_q;
  assign bus.event_o        = event_q;
  assign bus.sticky_o       = sticky_q;
  assign bus.any_event_o    = |event_q;

endmodule
